// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : shared constants, sample type and bit-reverse helper for the FFT
// rev 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_PTS  = 32;
  localparam int FFT_LOG2 = 5;
  localparam int FFT_N    = 16;

  typedef struct packed {
    logic signed [FFT_N-1:0] re;
    logic signed [FFT_N-1:0] im;
  } cplx_t;

  function automatic logic [FFT_LOG2-1:0] bitrev(input logic [FFT_LOG2-1:0] v);
    logic [FFT_LOG2-1:0] r;
    for (int b = 0; b < FFT_LOG2; b++) begin
      r[b] = v[FFT_LOG2-1-b];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_sample_bank.sv
// ============================================================================
// fft_sample_bank : two-bank sample store, one write port, two async read ports
// rev 1.0
// ============================================================================
`default_nettype none

module fft_sample_bank #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW:0]   rd_addr0,
  input  logic [AW:0]   rd_addr1,
  output logic [W-1:0]  rd_data0,
  output logic [W-1:0]  rd_data1
);

  // Address MSB selects the bank; contents are intentionally left unreset.
  logic [W-1:0] mem [2**(AW+1)];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data0 = mem[rd_addr0];
  assign rd_data1 = mem[rd_addr1];

endmodule

`default_nettype wire

// File: rtl/fft_input_reorder.sv
// ============================================================================
// fft_input_reorder : natural-order samples in, bit-reversed butterfly pairs out
// rev 1.0
// ============================================================================
`default_nettype none

module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int N        = 16,
  parameter int LOG2_PTS = FFT_LOG2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_r,
  input  logic [N-1:0] in_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out0_r,
  output logic [N-1:0] out0_i,
  output logic [N-1:0] out1_r,
  output logic [N-1:0] out1_i,
  output logic         out_last
);

  logic [1:0]          bank_full;
  logic [1:0]          full_next;
  logic                wr_bank;
  logic                rd_bank;
  logic [LOG2_PTS-1:0] wr_cnt;
  logic [LOG2_PTS-2:0] rd_cnt;
  logic                wr_fire;
  logic                wr_last;
  logic                load;
  logic                rd_last;
  logic [LOG2_PTS-1:0] addr0;
  logic [LOG2_PTS-1:0] addr1;
  logic [2*N-1:0]      rd_data0;
  logic [2*N-1:0]      rd_data1;

  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = in_valid & in_ready & !rst;
  assign wr_last  = wr_fire & (&wr_cnt);
  assign load     = bank_full[rd_bank] & (!out_valid | out_ready);
  assign rd_last  = load & (&rd_cnt);

  // bitrev(2k) is always below PTS/2, so the partner address just sets the MSB.
  assign addr0 = bitrev({rd_cnt, 1'b0});
  assign addr1 = {1'b1, addr0[LOG2_PTS-2:0]};

  fft_sample_bank #(
    .W  (2*N),
    .AW (LOG2_PTS)
  ) u_bank (
    .clk      (clk),
    .wr_en    (wr_fire),
    .wr_addr  ({wr_bank, wr_cnt}),
    .wr_data  ({in_r, in_i}),
    .rd_addr0 ({rd_bank, addr0}),
    .rd_addr1 ({rd_bank, addr1}),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

  always_comb begin
    full_next = bank_full;
    if (rd_last) full_next[rd_bank] = 1'b0;
    if (wr_last) full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out0_r    <= '0;
      out0_i    <= '0;
      out1_r    <= '0;
      out1_i    <= '0;
    end else begin
      bank_full <= full_next;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
      if (load) begin
        out_valid        <= 1'b1;
        out_last         <= rd_last;
        {out0_r, out0_i} <= rd_data0;
        {out1_r, out1_i} <= rd_data1;
        rd_cnt           <= rd_cnt + 1'b1;
        if (rd_last) rd_bank <= ~rd_bank;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
